// File: rtl/key_buf_pkg.sv
// Keypoint payload layout shared by the keypoint buffering blocks.
// The field order inside kp_t matches the packed DW-bit payload, MSB first.
package key_buf_pkg;

    localparam int KP_SIN_W   = 12;
    localparam int KP_COS_W   = 12;
    localparam int KP_X_W     = 10;
    localparam int KP_Y_W     = 10;
    localparam int KP_SCORE_W = 8;
    localparam int KP_DW      = KP_SIN_W + KP_COS_W + KP_X_W + KP_Y_W + KP_SCORE_W;

    typedef struct packed {
        logic [KP_SIN_W-1:0]   sin;
        logic [KP_COS_W-1:0]   cos;
        logic [KP_X_W-1:0]     x;
        logic [KP_Y_W-1:0]     y;
        logic [KP_SCORE_W-1:0] score;
    } kp_t;

endpackage

// File: rtl/kp_ring_mem.sv
// Ring storage for the delay queue: DEPTH x WW flops, one write port and one asynchronous read port.
// The array is intentionally left out of reset; occupancy tracking decides what is live.
module kp_ring_mem #(
    parameter int  DEPTH = 16,
    parameter int  WW    = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [WW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [WW-1:0] o_rdata
);

    logic [WW-1:0] mem_q [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/key_delay_queue.sv
// Holds keypoints for DELAY pixel steps and releases them in arrival order.
// Each entry carries the step timestamp at insertion; the head is popped once its age reaches DELAY.
module key_delay_queue
    import key_buf_pkg::*;
#(
    parameter int  DEPTH = 16,
    parameter int  DELAY = 100,
    parameter int  DW    = KP_DW,
    parameter int  TW    = 12,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_step,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_clear,
    output logic          o_valid,
    output logic [DW-1:0] o_data,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty,
    output logic [15:0]   o_drop_cnt
);

    localparam int              AW      = $clog2(DEPTH);
    localparam int              EW      = DW + TW;
    localparam logic [TW-1:0]   DELAY_T = TW'(DELAY);
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);

    logic [TW-1:0] tcnt_q,   tcnt_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          full_q,   full_d;
    logic          empty_q,  empty_d;
    logic [15:0]   drop_q,   drop_d;
    logic          valid_q,  valid_d;
    logic [DW-1:0] data_q,   data_d;

    logic [EW-1:0] head_w;
    logic [DW-1:0] head_data;
    logic [TW-1:0] head_stamp;
    logic [TW-1:0] head_age;
    logic          pop;
    logic          push_ok;
    logic          mem_we;

    kp_ring_mem #(
        .DEPTH (DEPTH),
        .WW    (EW)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (mem_we),
        .i_waddr (wr_ptr_q),
        .i_wdata ({i_data, tcnt_q}),
        .i_raddr (rd_ptr_q),
        .o_rdata (head_w)
    );

    assign {head_data, head_stamp} = head_w;

    // Modular subtraction keeps the age correct across timestamp wrap.
    assign head_age = tcnt_q - head_stamp;
    assign pop      = !empty_q && (head_age >= DELAY_T);
    assign push_ok  = i_push && (!full_q || pop);
    assign mem_we   = push_ok && !i_clear;

    always_comb begin
        tcnt_d   = tcnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        drop_d   = drop_q;
        valid_d  = 1'b0;
        data_d   = data_q;

        if (i_clear) begin
            tcnt_d   = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            drop_d   = '0;
        end else begin
            if (i_step) begin
                tcnt_d = tcnt_q + TW'(1);
            end
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                valid_d  = 1'b1;
                data_d   = head_data;
            end
            if (push_ok && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push_ok) begin
                count_d = count_q - CW'(1);
            end
            if (i_push && !push_ok && (drop_q != 16'hFFFF)) begin
                drop_d = drop_q + 16'd1;
            end
        end

        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tcnt_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            drop_q   <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            tcnt_q   <= tcnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            drop_q   <= drop_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
        end
    end

    assign o_valid    = valid_q;
    assign o_data     = data_q;
    assign o_count    = count_q;
    assign o_full     = full_q;
    assign o_empty    = empty_q;
    assign o_drop_cnt = drop_q;

endmodule

// File: tb/tb_key_delay_queue.sv
// Directed bench for key_delay_queue (DEPTH=4, DELAY=4, TW=8) with a release scoreboard.
// Stimulus queues {payload, expected cycle}; the monitor pops one entry per o_valid strobe.
module tb_key_delay_queue;

    localparam int DEPTH = 4;
    localparam int DELAY = 4;
    localparam int TW    = 8;
    localparam int DW    = 52;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          step  = 1'b0;
    logic          push  = 1'b0;
    logic          clear = 1'b0;
    logic [DW-1:0] data  = '0;
    logic          o_valid;
    logic [DW-1:0] o_data;
    logic [CW-1:0] o_count;
    logic          o_full;
    logic          o_empty;
    logic [15:0]   o_drop_cnt;

    key_delay_queue #(
        .DEPTH (DEPTH),
        .DELAY (DELAY),
        .DW    (DW),
        .TW    (TW)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_step     (step),
        .i_push     (push),
        .i_data     (data),
        .i_clear    (clear),
        .o_valid    (o_valid),
        .o_data     (o_data),
        .o_count    (o_count),
        .o_full     (o_full),
        .o_empty    (o_empty),
        .o_drop_cnt (o_drop_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        int            when;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && o_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_release: got data %0h at cycle %0d, expected no release", o_data, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("release_data", 64'(o_data), 64'(e.data));
                chk("release_cycle", 64'(cyc), 64'(e.when));
            end
        end
    end

    // Inputs change just after a falling edge and are sampled on the next rising edge.
    task automatic drive(input logic p, input logic [DW-1:0] d, input logic s, input logic c);
        push  = p;
        data  = d;
        step  = s;
        clear = c;
        @(negedge clk);
        push  = 1'b0;
        step  = 1'b0;
        clear = 1'b0;
    endtask

    task automatic expect_at(input logic [DW-1:0] d, input int offset);
        exp_t e;
        e.data = d;
        e.when = cyc + offset;
        exp_q.push_back(e);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected simulation end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_data", 64'(o_data), 64'd0);
        chk("rst_count", 64'(o_count), 64'd0);
        chk("rst_full", 64'(o_full), 64'd0);
        chk("rst_empty", 64'(o_empty), 64'd1);
        chk("rst_drop", 64'(o_drop_cnt), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single entry: released 5 edges after the first of four steps
        drive(1'b1, 52'hA5, 1'b0, 1'b0);
        chk("single_count", 64'(o_count), 64'd1);
        chk("single_empty", 64'(o_empty), 64'd0);
        expect_at(52'hA5, 5);
        steps(12);
        chk("single_drained", 64'(o_empty), 64'd1);

        // Overflow: fifth push dropped, four released back to back
        for (int i = 0; i < 5; i++) drive(1'b1, 52'(32'h100 + i), 1'b0, 1'b0);
        chk("ovf_full", 64'(o_full), 64'd1);
        chk("ovf_count", 64'(o_count), 64'd4);
        chk("ovf_drop", 64'(o_drop_cnt), 64'd1);
        for (int i = 0; i < 4; i++) expect_at(52'(32'h100 + i), 5 + i);
        steps(4);
        idle(6);
        chk("ovf_count_after", 64'(o_count), 64'd0);
        chk("ovf_full_after", 64'(o_full), 64'd0);

        // Two pushes between the same steps, then a push coinciding with a step
        drive(1'b1, 52'h11, 1'b0, 1'b0);
        drive(1'b1, 52'h22, 1'b0, 1'b0);
        expect_at(52'h11, 5);
        expect_at(52'h22, 6);
        steps(4);
        idle(4);
        expect_at(52'h33, 5);
        drive(1'b1, 52'h33, 1'b1, 1'b0);
        steps(3);
        idle(4);

        // Timestamp wrap: stamp 254, release only once tcnt reaches 2
        drive(1'b0, '0, 1'b0, 1'b1);
        chk("wrap_clear_count", 64'(o_count), 64'd0);
        steps(254);
        drive(1'b1, 52'h3C, 1'b0, 1'b0);
        expect_at(52'h3C, 5);
        steps(4);
        idle(4);

        // Clear flushes entries and drop count but keeps o_data
        for (int i = 0; i < 5; i++) drive(1'b1, 52'(32'hC1 + i), 1'b0, 1'b0);
        chk("clr_pre_full", 64'(o_full), 64'd1);
        chk("clr_pre_drop", 64'(o_drop_cnt), 64'd1);
        drive(1'b0, '0, 1'b0, 1'b1);
        chk("clr_count", 64'(o_count), 64'd0);
        chk("clr_empty", 64'(o_empty), 64'd1);
        chk("clr_full", 64'(o_full), 64'd0);
        chk("clr_drop", 64'(o_drop_cnt), 64'd0);
        chk("clr_valid", 64'(o_valid), 64'd0);
        chk("clr_data_hold", 64'(o_data), 64'h3C);
        drive(1'b1, 52'hDD, 1'b1, 1'b1);
        chk("clr_push_prio", 64'(o_count), 64'd0);
        steps(10);

        // Asynchronous reset in the middle of a release burst
        drive(1'b1, 52'hE1, 1'b0, 1'b0);
        drive(1'b1, 52'hE2, 1'b0, 1'b0);
        drive(1'b1, 52'hE3, 1'b0, 1'b0);
        expect_at(52'hE1, 5);
        steps(4);
        idle(1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(o_valid), 64'd0);
        chk("arst_data", 64'(o_data), 64'd0);
        chk("arst_count", 64'(o_count), 64'd0);
        chk("arst_full", 64'(o_full), 64'd0);
        chk("arst_empty", 64'(o_empty), 64'd1);
        chk("arst_drop", 64'(o_drop_cnt), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        steps(12);
        chk("arst_stays_empty", 64'(o_empty), 64'd1);

        chk("pending_releases", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
